iccm_banked_ctrl: RTL and testbench

//  Next-generation ICCM controller: front-end between core fetch/DMA write ports and an N-bank

---
 rtl/iccm_banked_ctrl.sv | 132 +++++++++++++
 tb/tb_iccm_banked_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_banked_ctrl.sv
// Banked ICCM front-end: parallel read/write issue to interleaved SRAM banks, write-priority
// same-bank arbitration with read starvation guard, registered memory-side requests.
module iccm_banked_ctrl #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BANKS    = 2,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3,
  localparam int BS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  localparam int BAW = ADDR_WIDTH - BS,
  localparam int BEW = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_req,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_ready,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [BEW-1:0]                 wr_be,
  output logic                           wr_ready,
  output logic [NUM_BANKS-1:0]           mem_rd,
  output logic [NUM_BANKS-1:0]           mem_wr,
  output logic [NUM_BANKS*BAW-1:0]       mem_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wdata,
  output logic [NUM_BANKS*BEW-1:0]       mem_be,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata
);

  localparam int TW  = (BS > 0) ? BS : 1;
  localparam int D   = 1 + MEM_LATENCY;
  localparam int SCW = 4;

  function automatic logic [TW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    if (BS == 0) return '0;
    else return a[TW-1:0];
  endfunction

  logic [TW-1:0]   rd_bank;
  logic [TW-1:0]   wr_bank;
  logic [BAW-1:0]  rd_baddr;
  logic [BAW-1:0]  wr_baddr;
  logic            conflict;
  logic            starved;
  logic            rd_acc;
  logic            wr_acc;
  logic [SCW-1:0]  starve_cnt;
  logic [D-1:0]    pipe_vld;
  logic [TW-1:0]   pipe_tag [D];
  logic [DATA_WIDTH-1:0] rd_slice;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign rd_bank  = bank_of(rd_addr);
  assign wr_bank  = bank_of(wr_addr);
  assign rd_baddr = rd_addr[ADDR_WIDTH-1:BS];
  assign wr_baddr = wr_addr[ADDR_WIDTH-1:BS];

  assign conflict = rd_req && wr_req && (rd_bank == wr_bank);
  assign starved  = (starve_cnt == SCW'(STARVE_LIMIT));
  assign rd_ready = !conflict || starved;
  assign wr_ready = !conflict || !starved;
  assign rd_acc   = rd_req && rd_ready;
  // A zero-byte-enable write is accepted but never reaches the SRAM.
  assign wr_acc   = wr_req && wr_ready && (|wr_be);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_acc) begin
      starve_cnt <= '0;
    end else if (rd_req && !starved) begin
      starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd    <= '0;
      mem_wr    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem_rd[b] <= rd_acc && (rd_bank == TW'(b));
        mem_wr[b] <= wr_acc && (wr_bank == TW'(b));
        if (rd_acc && (rd_bank == TW'(b))) begin
          mem_addr[b*BAW +: BAW] <= rd_baddr;
        end
        if (wr_acc && (wr_bank == TW'(b))) begin
          mem_addr[b*BAW +: BAW]               <= wr_baddr;
          mem_wdata[b*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
          mem_be[b*BEW +: BEW]                 <= wr_be;
        end
      end
    end
  end

  // Bank tag travels alongside the read so the return slice can be selected at the SRAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < D; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld <= {pipe_vld[D-2:0], rd_acc};
      pipe_tag[0] <= rd_bank;
      for (int i = 1; i < D; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_comb begin
    rd_slice = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pipe_tag[D-1] == TW'(b)) rd_slice = mem_rdata[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (pipe_vld[D-1]) begin
      rd_data_q <= rd_slice;
    end
  end

  assign rd_valid = pipe_vld[D-1];
  assign rd_data  = rd_valid ? rd_slice : rd_data_q;

endmodule

// File: tb/tb_iccm_banked_ctrl.sv
// Directed bench for iccm_banked_ctrl with a behavioural banked SRAM (1-cycle registered read).
module tb_iccm_banked_ctrl;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int NB  = 2;
  localparam int BEW = 4;
  localparam int BAW = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_ready;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BEW-1:0] wr_be;
  logic wr_ready;
  logic [NB-1:0] mem_rd;
  logic [NB-1:0] mem_wr;
  logic [NB*BAW-1:0] mem_addr;
  logic [NB*DW-1:0] mem_wdata;
  logic [NB*BEW-1:0] mem_be;
  logic [NB*DW-1:0] mem_rdata;

  logic mem_init;
  logic [DW-1:0] sram [NB][1<<BAW];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iccm_banked_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .MEM_LATENCY(1), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM: word at global address a holds 0xC0000000 | a until overwritten.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < (1 << BAW); i++)
          sram[b][i] <= 32'hC000_0000 | 32'(i * NB + b);
      mem_rdata <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (mem_rd[b]) mem_rdata[b*DW +: DW] <= sram[b][mem_addr[b*BAW +: BAW]];
        if (mem_wr[b])
          for (int k = 0; k < BEW; k++)
            if (mem_be[b*BEW + k])
              sram[b][mem_addr[b*BAW +: BAW]][k*8 +: 8] <= mem_wdata[b*DW + k*8 +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    @(negedge clk); rd_req = 1'b1; rd_addr = a;
    @(negedge clk); rd_req = 1'b0;
    @(posedge clk); #1;
    check({name, "_vld"}, 64'(rd_valid), 64'd1);
    check({name, "_dat"}, 64'(rd_data), 64'(exp));
  endtask

  typedef struct packed {
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [BEW-1:0] wr_be;
    logic          exp_rd_rdy;
    logic          exp_wr_rdy;
    logic [NB-1:0] exp_mem_rd;
    logic [NB-1:0] exp_mem_wr;
  } vec_t;

  vec_t vecs [9];
  int seen;

  initial begin
    vecs[0] = '{1'b1, 11'h004, 1'b0, 11'h000, 4'h0, 1'b1, 1'b1, 2'b01, 2'b00};
    vecs[1] = '{1'b1, 11'h005, 1'b1, 11'h008, 4'hF, 1'b1, 1'b1, 2'b10, 2'b01};
    vecs[2] = '{1'b0, 11'h000, 1'b0, 11'h000, 4'h0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[3] = '{1'b0, 11'h000, 1'b1, 11'h003, 4'hF, 1'b1, 1'b1, 2'b00, 2'b10};
    vecs[4] = '{1'b1, 11'h006, 1'b1, 11'h00A, 4'hF, 1'b0, 1'b1, 2'b00, 2'b01};
    vecs[5] = '{1'b1, 11'h007, 1'b0, 11'h000, 4'h0, 1'b1, 1'b1, 2'b10, 2'b00};
    vecs[6] = '{1'b0, 11'h000, 1'b1, 11'h009, 4'h0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[7] = '{1'b1, 11'h001, 1'b1, 11'h00B, 4'h0, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[8] = '{1'b1, 11'h001, 1'b0, 11'h000, 4'h0, 1'b1, 1'b1, 2'b10, 2'b00};

    idle();
    rst_n = 1'b0; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_rd_ready", 64'(rd_ready), 64'd1);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk); mem_init = 1'b0; rst_n = 1'b1;

    // Single read, bank 0: issue next cycle, data two cycles after accept.
    @(negedge clk); rd_req = 1'b1; rd_addr = 11'h004;
    @(posedge clk); #1;
    check("t1_mem_rd", 64'(mem_rd), 64'b01);
    check("t1_mem_addr", 64'(mem_addr[BAW-1:0]), 64'h002);
    check("t1_early_vld", 64'(rd_valid), 64'd0);
    @(negedge clk); rd_req = 1'b0;
    @(posedge clk); #1;
    check("t1_vld", 64'(rd_valid), 64'd1);
    check("t1_dat", 64'(rd_data), 64'hC000_0004);
    check("t1_strobe_once", 64'(mem_rd), 64'd0);
    @(posedge clk); #1;
    check("t1_vld_pulse", 64'(rd_valid), 64'd0);
    check("t1_dat_hold", 64'(rd_data), 64'hC000_0004);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr;
      wr_req = vecs[i].wr_req; wr_addr = vecs[i].wr_addr;
      wr_be = vecs[i].wr_be; wr_data = 32'h1234_5678;
      #1;
      check($sformatf("v%0d_rd_ready", i), 64'(rd_ready), 64'(vecs[i].exp_rd_rdy));
      check($sformatf("v%0d_wr_ready", i), 64'(wr_ready), 64'(vecs[i].exp_wr_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_mem_rd", i), 64'(mem_rd), 64'(vecs[i].exp_mem_rd));
      check($sformatf("v%0d_mem_wr", i), 64'(mem_wr), 64'(vecs[i].exp_mem_wr));
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);

    // Starvation: bank-0 writes every cycle against a bank-0 read.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 11'h000; wr_data = 32'h0; wr_be = 4'hF;
      rd_req = 1'b1; rd_addr = 11'h002;
      #1;
      check($sformatf("starve_c%0d_rd_ready", c), 64'(rd_ready), 64'(c == 4));
      check($sformatf("starve_c%0d_wr_ready", c), 64'(wr_ready), 64'(c != 4));
    end
    @(posedge clk); #1;
    check("starve_mem_rd", 64'(mem_rd), 64'b01);
    check("starve_mem_wr", 64'(mem_wr), 64'b00);
    @(negedge clk); rd_req = 1'b0; #1;
    check("starve_after_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);

    // Partial byte-enable write followed by read of the same word.
    @(negedge clk); wr_req = 1'b1; wr_addr = 11'h010; wr_data = 32'hA5A5_A5A5; wr_be = 4'b0011;
    @(posedge clk); #1;
    check("be_mem_wr", 64'(mem_wr), 64'b01);
    check("be_mem_be", 64'(mem_be[BEW-1:0]), 64'b0011);
    check("be_mem_wdata", 64'(mem_wdata[DW-1:0]), 64'hA5A5_A5A5);
    check("be_mem_addr", 64'(mem_addr[BAW-1:0]), 64'h008);
    @(negedge clk); idle();
    rd_req = 1'b1; rd_addr = 11'h010;
    @(negedge clk); rd_req = 1'b0;
    @(posedge clk); #1;
    check("be_rd_vld", 64'(rd_valid), 64'd1);
    check("be_rd_merged", 64'(rd_data), 64'hC000_A5A5);

    // Read then write of the same word: read sees the old value.
    @(negedge clk); rd_req = 1'b1; rd_addr = 11'h012;
    @(negedge clk); rd_req = 1'b0; wr_req = 1'b1; wr_addr = 11'h012; wr_data = 32'h0; wr_be = 4'hF;
    @(posedge clk); #1;
    check("rw_old_vld", 64'(rd_valid), 64'd1);
    check("rw_old_dat", 64'(rd_data), 64'hC000_0012);
    @(negedge clk); idle();
    do_read(11'h012, 32'h0, "rw_new");

    // Back-to-back reads across both banks.
    @(negedge clk); rd_req = 1'b1; rd_addr = 11'h020;
    @(negedge clk); rd_addr = 11'h021;
    @(negedge clk); rd_req = 1'b0;
    check("b2b_a_vld", 64'(rd_valid), 64'd1);
    check("b2b_a_dat", 64'(rd_data), 64'hC000_0020);
    @(negedge clk);
    check("b2b_b_vld", 64'(rd_valid), 64'd1);
    check("b2b_b_dat", 64'(rd_data), 64'hC000_0021);
    @(negedge clk);
    check("b2b_end_vld", 64'(rd_valid), 64'd0);

    // Reset with two reads in flight.
    @(negedge clk); rd_req = 1'b1; rd_addr = 11'h004;
    @(negedge clk); rd_addr = 11'h006;
    @(posedge clk); #1;
    rst_n = 1'b0; rd_req = 1'b0;
    #1;
    check("flush_rd_valid", 64'(rd_valid), 64'd0);
    check("flush_mem_rd", 64'(mem_rd), 64'd0);
    check("flush_mem_wr", 64'(mem_wr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid || (mem_rd != '0) || (mem_wr != '0)) seen++;
    end
    check("flush_no_activity", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
